// File: rtl/pp_bbox_pkg.sv
// Shared FSM encoding, default geometry and result payload for the red-pixel bbox tracker.
package pp_bbox_pkg;

  localparam int unsigned DEF_IMG_W = 640;
  localparam int unsigned DEF_IMG_H = 480;
  localparam int unsigned DEF_XW    = $clog2(DEF_IMG_W);
  localparam int unsigned DEF_YW    = $clog2(DEF_IMG_H);
  localparam int unsigned DEF_CNT_W = $clog2(DEF_IMG_W * DEF_IMG_H + 1);

  typedef enum logic [1:0] {
    ST_WAIT_SOF = 2'd0,
    ST_ACCUM    = 2'd1,
    ST_REPORT   = 2'd2
  } bbox_state_t;

  // End-of-frame result as seen by overlay/control stages at default geometry.
  typedef struct packed {
    logic [DEF_XW-1:0]    x_min;
    logic [DEF_XW-1:0]    x_max;
    logic [DEF_YW-1:0]    y_min;
    logic [DEF_YW-1:0]    y_max;
    logic [DEF_CNT_W-1:0] red_count;
    logic                 found;
  } bbox_result_t;

endpackage

// File: rtl/pp_pixel_position_counter.sv
// Raster x/y tracker: advances on accepted pixels, resyncs to (0,0) on a frame-start pixel,
// and flags the row-end and last pixel of the frame for the current pixel.
module pp_pixel_position_counter #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned XW    = 10,
  parameter int unsigned YW    = 9
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          advance,
  input  logic          restart,
  output logic [XW-1:0] pix_x_c,
  output logic [YW-1:0] pix_y_c,
  output logic          row_end_c,
  output logic          last_c
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  // Registers hold the position of the next pixel; a restart pixel is (0,0) regardless.
  assign pix_x_c   = restart ? '0 : x;
  assign pix_y_c   = restart ? '0 : y;
  assign row_end_c = (pix_x_c == X_LAST);
  assign last_c    = row_end_c && (pix_y_c == Y_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (row_end_c) begin
        x <= '0;
        y <= last_c ? '0 : pix_y_c + YW'(1);
      end else begin
        x <= pix_x_c + XW'(1);
        y <= pix_y_c;
      end
    end
  end

endmodule

// File: rtl/pp_red_bbox_tracker.sv
// Per-frame bounding box and count of red pixels, reported once per frame.
// Optional PP_RED_RUN_FILTER_EN: only the RUN_LEN-th and later consecutive red pixels of a row count.
module pp_red_bbox_tracker
  import pp_bbox_pkg::*;
#(
  parameter int unsigned IMG_W      = DEF_IMG_W,
  parameter int unsigned IMG_H      = DEF_IMG_H,
  parameter int unsigned XW         = DEF_XW,
  parameter int unsigned YW         = DEF_YW,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned MIN_PIXELS = 64,
  parameter int unsigned RUN_LEN    = 3
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_valid,
  input  logic             i_pixel_is_red,
  input  logic             i_sof,
  output logic [XW-1:0]    o_x_min,
  output logic [XW-1:0]    o_x_max,
  output logic [YW-1:0]    o_y_min,
  output logic [YW-1:0]    o_y_max,
  output logic [CNT_W-1:0] o_red_count,
  output logic             o_found,
  output logic             o_bbox_valid
);

  localparam logic [XW-1:0]    X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0]    Y_LAST  = YW'(IMG_H - 1);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PIXELS);

  bbox_state_t      state;
  logic             restart_c, take_c, fresh_c, row_end_c, last_c, count_red_c, found_c;
  logic [XW-1:0]    pix_x_c;
  logic [YW-1:0]    pix_y_c;
  logic [XW-1:0]    acc_x_min, acc_x_max, nxt_x_min, nxt_x_max;
  logic [YW-1:0]    acc_y_min, acc_y_max, nxt_y_min, nxt_y_max;
  logic [CNT_W-1:0] acc_count, nxt_count;

  pp_pixel_position_counter #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .XW   (XW),
    .YW   (YW)
  ) u_pos (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .advance  (take_c),
    .restart  (restart_c),
    .pix_x_c  (pix_x_c),
    .pix_y_c  (pix_y_c),
    .row_end_c(row_end_c),
    .last_c   (last_c)
  );

`ifdef PP_RED_RUN_FILTER_EN
  localparam int unsigned RUN_W = $clog2(RUN_LEN + 1);

  logic [RUN_W-1:0] run_cnt, run_base_c, run_inc_c;

  // Run length saturates at RUN_LEN; a pixel qualifies once the run including it reaches RUN_LEN.
  always_comb begin
    run_base_c  = fresh_c ? '0 : run_cnt;
    run_inc_c   = (run_base_c == RUN_W'(RUN_LEN)) ? run_base_c : run_base_c + RUN_W'(1);
    count_red_c = i_pixel_is_red && (run_inc_c >= RUN_W'(RUN_LEN));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      run_cnt <= '0;
    end else if (take_c) begin
      run_cnt <= (row_end_c || !i_pixel_is_red) ? '0 : run_inc_c;
    end else begin
      run_cnt <= run_base_c;
    end
  end
`else
  assign count_red_c = i_pixel_is_red;

  // RUN_LEN only shapes the run filter build.
  if (RUN_LEN == 0) begin : g_run_len_unused
  end
`endif

  // Accumulators start fresh on a frame-start pixel and whenever no frame is being accumulated.
  always_comb begin
    restart_c = i_valid && i_sof;
    take_c    = i_valid && (i_sof || (state == ST_ACCUM));
    fresh_c   = restart_c || (state != ST_ACCUM);
    nxt_x_min = fresh_c ? X_LAST : acc_x_min;
    nxt_x_max = fresh_c ? '0 : acc_x_max;
    nxt_y_min = fresh_c ? Y_LAST : acc_y_min;
    nxt_y_max = fresh_c ? '0 : acc_y_max;
    nxt_count = fresh_c ? '0 : acc_count;
    if (take_c && count_red_c) begin
      if (pix_x_c < nxt_x_min) nxt_x_min = pix_x_c;
      if (pix_x_c > nxt_x_max) nxt_x_max = pix_x_c;
      if (pix_y_c < nxt_y_min) nxt_y_min = pix_y_c;
      if (pix_y_c > nxt_y_max) nxt_y_max = pix_y_c;
      if (nxt_count != '1) nxt_count = nxt_count + CNT_W'(1);
    end
  end

  assign found_c = (acc_count >= CNT_MIN);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state        <= ST_WAIT_SOF;
      acc_x_min    <= X_LAST;
      acc_x_max    <= '0;
      acc_y_min    <= Y_LAST;
      acc_y_max    <= '0;
      acc_count    <= '0;
      o_x_min      <= '0;
      o_x_max      <= '0;
      o_y_min      <= '0;
      o_y_max      <= '0;
      o_red_count  <= '0;
      o_found      <= 1'b0;
      o_bbox_valid <= 1'b0;
    end else begin
      acc_x_min    <= nxt_x_min;
      acc_x_max    <= nxt_x_max;
      acc_y_min    <= nxt_y_min;
      acc_y_max    <= nxt_y_max;
      acc_count    <= nxt_count;
      o_bbox_valid <= (state == ST_REPORT);

      if (state == ST_REPORT) begin
        o_found     <= found_c;
        o_red_count <= acc_count;
        o_x_min     <= found_c ? acc_x_min : '0;
        o_x_max     <= found_c ? acc_x_max : '0;
        o_y_min     <= found_c ? acc_y_min : '0;
        o_y_max     <= found_c ? acc_y_max : '0;
      end

      if (take_c && last_c) begin
        state <= ST_REPORT;
      end else if (restart_c) begin
        state <= ST_ACCUM;
      end else if (state == ST_REPORT) begin
        state <= ST_WAIT_SOF;
      end
    end
  end

endmodule

// File: tb/tb_pp_red_bbox_tracker.sv
// Scoreboard bench for pp_red_bbox_tracker on an 8x4 image with randomized valid gaps.
module tb_pp_red_bbox_tracker;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int NPX  = W * H;
  localparam int MINP = 2;
  localparam int RUNL = 2;

  typedef struct {
    int xmn, xmx, ymn, ymx, cnt, found, cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn, valid, red, sof;
  logic [2:0] x_min, x_max;
  logic [1:0] y_min, y_max;
  logic [5:0] red_count;
  logic       found, bbox_valid;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  pp_red_bbox_tracker #(
    .IMG_W(W), .IMG_H(H), .XW(3), .YW(2), .CNT_W(6), .MIN_PIXELS(MINP), .RUN_LEN(RUNL)
  ) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_valid       (valid),
    .i_pixel_is_red(red),
    .i_sof         (sof),
    .o_x_min       (x_min),
    .o_x_max       (x_max),
    .o_y_min       (y_min),
    .o_y_max       (y_max),
    .o_red_count   (red_count),
    .o_found       (found),
    .o_bbox_valid  (bbox_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: scan the frame row by row, qualify red pixels, then take extents.
  function automatic exp_t model(input logic [NPX-1:0] reds);
    exp_t e;
    int   run, cnt, xmn, xmx, ymn, ymx;
    bit   q;
    cnt = 0; xmn = W; xmx = -1; ymn = H; ymx = -1;
    for (int yy = 0; yy < H; yy++) begin
      run = 0;
      for (int xx = 0; xx < W; xx++) begin
        run = reds[yy*W+xx] ? run + 1 : 0;
`ifdef PP_RED_RUN_FILTER_EN
        q = (run >= RUNL);
`else
        q = reds[yy*W+xx];
`endif
        if (q) begin
          cnt++;
          if (xx < xmn) xmn = xx;
          if (xx > xmx) xmx = xx;
          if (yy < ymn) ymn = yy;
          if (yy > ymx) ymx = yy;
        end
      end
    end
    e.cnt   = cnt;
    e.found = (cnt >= MINP) ? 1 : 0;
    e.xmn   = e.found ? xmn : 0;
    e.xmx   = e.found ? xmx : 0;
    e.ymn   = e.found ? ymn : 0;
    e.ymx   = e.found ? ymx : 0;
    e.cyc   = 0;
    return e;
  endfunction

  task automatic drive_px(input logic v, input logic s, input logic r);
    valid = v;
    sof   = s;
    red   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive_px(1'b0, 1'($urandom), 1'($urandom));
  endtask

  // Drives one frame; abort_at >= 0 stops before that pixel index without reporting.
  task automatic drive_frame(input logic [NPX-1:0] reds, input int gap_pct,
                             input int pre_last_idle, input int abort_at);
    exp_t e;
    int   n;
    for (int p = 0; p < NPX; p++) begin
      if (p == abort_at) return;
      n = 0;
      while (($urandom_range(99) < gap_pct) && (n < 6)) begin
        idle();
        n++;
      end
      if (p == NPX - 1) begin
        repeat (pre_last_idle) idle();
        e     = model(reds);
        e.cyc = cyc + 2;
        exp_q.push_back(e);
      end
      drive_px(1'b1, p == 0, reds[p]);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    @(negedge clk);
    chk({tag, "_x_min"}, int'(x_min), 0);
    chk({tag, "_x_max"}, int'(x_max), 0);
    chk({tag, "_y_min"}, int'(y_min), 0);
    chk({tag, "_y_max"}, int'(y_max), 0);
    chk({tag, "_count"}, int'(red_count), 0);
    chk({tag, "_found"}, int'(found), 0);
    chk({tag, "_valid"}, int'(bbox_valid), 0);
  endtask

  // Monitor: every result pulse must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (bbox_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("x_min", int'(x_min), e.xmn);
        chk("x_max", int'(x_max), e.xmx);
        chk("y_min", int'(y_min), e.ymn);
        chk("y_max", int'(y_max), e.ymx);
        chk("red_count", int'(red_count), e.cnt);
        chk("found", int'(found), e.found);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NPX-1:0] t1, t2, t4, t6, r;
    t1 = '0; t1[1*W+2] = 1'b1; t1[3*W+5] = 1'b1;
    t2 = '0; t2[2*W+4] = 1'b1;
    t4 = '0; t4[0] = 1'b1; t4[7] = 1'b1;
    t6 = '0; t6[1*W+1] = 1'b1; t6[1*W+4] = 1'b1; t6[1*W+5] = 1'b1; t6[1*W+6] = 1'b1;

    rstn = 1'b0; valid = 1'b0; sof = 1'b0; red = 1'b0;
    repeat (3) drive_px(1'b1, 1'b0, 1'b1);
    check_outputs_zero("reset");
    rstn = 1'b1;

    // Valid red pixels before any sof must be ignored.
    repeat (10) drive_px(1'b1, 1'b0, 1'b1);
    drive_frame(t1, 0, 0, -1);
    // Next frame starts in the report cycle.
    drive_frame(t2, 0, 0, -1);
    repeat (3) idle();
    drive_frame(t1, 40, 5, -1);
    repeat (2) idle();

    // Abort at row 2 by re-asserting sof, then a clean frame.
    drive_frame(32'hFFFF_FFFF, 20, 0, 2 * W);
    drive_frame(t4, 0, 0, -1);
    // Non-sof pixels in the report cycle and after are dropped.
    repeat (3) drive_px(1'b1, 1'b0, 1'b1);
    drive_frame(t6, 10, 0, -1);
    repeat (2) idle();

    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(3))
        0:       r = '0;
        1:       r = $urandom & $urandom & $urandom;
        2:       r = $urandom & $urandom;
        default: r = $urandom;
      endcase
      drive_frame(r, $urandom_range(50), $urandom_range(3), -1);
      case ($urandom_range(2))
        0: ;
        1: repeat ($urandom_range(1, 4)) drive_px(1'b1, 1'b0, 1'($urandom));
        default: repeat ($urandom_range(1, 4)) idle();
      endcase
    end

    // Mid-frame reset after a found frame: outputs clear and no partial report.
    drive_frame(t1, 0, 0, -1);
    repeat (3) idle();
    drive_frame(t1 | t6, 0, 0, 20);
    rstn = 1'b0;
    repeat (2) drive_px(1'b1, 1'b1, 1'b1);
    check_outputs_zero("midreset");
    rstn = 1'b1;
    repeat (5) drive_px(1'b1, 1'b0, 1'b1);
    drive_frame(t2 | t4, 25, 2, -1);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle();
    repeat (3) idle();
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pp_red_bbox_tracker.md
Name: pp_red_bbox_tracker

Overview:
- Downstream consumer of the red-pixel classifier stage. Takes the per-pixel "is red" flag stream with its valid strobe.
- Tracks raster position and accumulates, per frame, the bounding box and count of red pixels.
- At end of frame, emits one bbox result with a found/not-found decision for the overlay/control stages.

Parameters:
- IMG_W, 640, active pixels per row
- IMG_H, 480, active rows per frame
- XW, 10, x coordinate width (must hold IMG_W-1)
- YW, 9, y coordinate width (must hold IMG_H-1)
- CNT_W, 19, red-pixel counter width (must hold IMG_W*IMG_H)
- MIN_PIXELS, 64, minimum red count for o_found=1
- RUN_LEN, 3, consecutive-red run length (used only with the optional feature)

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset; synchronous, active-low; clock i_clk
- i_valid  in  1  pixel flag valid (matches upstream o_valid)
- i_pixel_is_red  in  1  red classification of current pixel
- i_sof  in  1  start of frame; qualified by i_valid; marks pixel (0,0)
- o_x_min  out  XW  bbox left column
- o_x_max  out  XW  bbox right column
- o_y_min  out  YW  bbox top row
- o_y_max  out  YW  bbox bottom row
- o_red_count  out  CNT_W  red pixels counted in the reported frame
- o_found  out  1  o_red_count >= MIN_PIXELS
- o_bbox_valid  out  1  one-cycle pulse; all result outputs updated on this cycle

Behaviour:
- Reset:
  - All outputs 0.
  - FSM in WAIT_SOF; x=0, y=0.
  - Accumulators cleared: min_x=IMG_W-1, min_y=IMG_H-1, max=0, count=0.
- FSM states:
  - WAIT_SOF
    - Valid pixels without i_sof are ignored.
    - i_valid&i_sof: pixel taken as (0,0), accumulated, go to ACCUM.
  - ACCUM
    - Each cycle with i_valid=1 accepts one pixel at (x,y).
    - Red pixel: min/max updated with (x,y); count increments, saturating at all-ones.
    - Position update: x++. At x==IMG_W-1, x wraps to 0 and y increments.
    - i_valid=0: everything holds. Gaps of any length are allowed.
  - Last pixel: pixel accepted at (IMG_W-1, IMG_H-1) moves the FSM to REPORT on that same edge.
  - REPORT (one cycle)
    - Result registers loaded; o_bbox_valid=1 for exactly this cycle; accumulators re-initialised.
    - Next state is WAIT_SOF.
    - i_valid&i_sof in REPORT: accepted as new frame pixel (0,0), go directly to ACCUM.
    - Other valid pixels in REPORT are dropped.
- Latency: last pixel sampled at edge N; results and o_bbox_valid visible after edge N+1.
- Result loading:
  - o_found = (count >= MIN_PIXELS).
  - If o_found=0, bbox outputs load 0 and o_red_count still loads the true count.
  - Outputs hold until the next REPORT.
- Early i_sof (i_valid&i_sof in ACCUM, not at (0,0)):
  - Current frame is aborted with no report.
  - Accumulators are re-initialised and the sof pixel is treated as (0,0) of a new frame, in the same cycle.
- The min/max compare uses the pre-update accumulator values. A red pixel on the first accepted pixel correctly yields min=max=(0,0).
- Reset mid-frame returns to the reset state. No partial report is issued.

Optional Feature:
- Macro: PP_RED_RUN_FILTER_EN.
- Defined:
  - A pixel counts as red only if it is the RUN_LEN-th or later consecutive red pixel in the current row.
  - The run counter clears on a non-red pixel, on row wrap, and on frame start.
  - The bbox uses the qualifying pixel's own x. The left edge is biased by RUN_LEN-1; this is accepted.
- Undefined: every red-flagged pixel counts. No run counter logic is synthesised.

Decomposition:
- Package pp_bbox_pkg:
  - FSM state enum (WAIT_SOF, ACCUM, REPORT)
  - default IMG_W/IMG_H
  - XW/YW/CNT_W derivation constants
  - bbox result struct typedef
- Sub-module pp_pixel_position_counter:
  - x/y raster counter with valid advance, sof resync and last-pixel flag.
  - Reusable by other per-pixel stages.

Test Plan (IMG_W=8, IMG_H=4, MIN_PIXELS=2, RUN_LEN=2):
- Full frame, red only at (2,1),(5,3), continuous valid -> one o_bbox_valid pulse after the edge following pixel (7,3); x_min=2, x_max=5, y_min=1, y_max=3, count=2, found=1.
- Frame with a single red pixel at (4,2) -> count=1, found=0, bbox outputs 0.
- Same as the first test with random i_valid gaps, including several idle cycles before the last pixel -> identical results; pulse one cycle after the last accepted pixel.
- i_sof re-asserted at row 2 mid-frame, then a full clean frame with red at (0,0),(7,0) -> no report for the aborted frame; one report x 0..7, y 0..0, count=2.
- Valid pixels before any i_sof after reset, then i_rstn low mid-frame -> no accumulation pre-sof; outputs 0 after reset; no pulse.
- PP_RED_RUN_FILTER_EN, row 1 reds at x=1 (isolated), x=4,5,6 -> count=2, x_min=5, x_max=6. Without the macro: count=4, x_min=1.
